// File: rtl/axi4_pkg.sv
// Shared AXI4 slave-side types, constants and address/response helpers.
// Latency: pure combinational functions, no state.
// Backpressure: n/a (types and functions only).
//
// Helpers work on a fixed 64-bit address container. Callers widen their
// address into it and truncate the result back. Low-order address bits do not
// depend on higher ones, so arithmetic stays modulo 2^ADDR_W for any
// ADDR_W <= 64.
package axi4_pkg;

  localparam int AXI4_ADDR_MAX_W      = 64;
  localparam int AXI4_BOUNDARY_4K     = 4096;
  localparam int AXI4_BOUNDARY_4K_LSB = $clog2(AXI4_BOUNDARY_4K);

  typedef logic [AXI4_ADDR_MAX_W-1:0] axi4_addr_t;

  typedef enum logic [2:0] {
    S1   = 3'd0,
    S2   = 3'd1,
    S4   = 3'd2,
    S8   = 3'd3,
    S16  = 3'd4,
    S32  = 3'd5,
    S64  = 3'd6,
    S128 = 3'd7
  } AXSize_t;

  typedef enum logic [1:0] {
    FIXED    = 2'd0,
    INCR     = 2'd1,
    WRAP     = 2'd2,
    RESERVED = 2'd3
  } AXBurst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } XRESP_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

  // Address of the beat following 'cur'. A WRAP window is aligned to its own
  // size and every beat lies inside it, so the lower bound can be derived from
  // the current beat. The start address does not need to be kept.
  function automatic axi4_addr_t axi4_next_addr(
    input axi4_addr_t cur,
    input logic [7:0] len,
    input AXSize_t    size,
    input AXBurst_t   burst
  );
    axi4_addr_t step;
    axi4_addr_t wrap_bytes;
    axi4_addr_t lower;
    axi4_addr_t nxt;
    step       = axi4_addr_t'(1) << size;
    wrap_bytes = (axi4_addr_t'(len) + axi4_addr_t'(1)) << size;
    lower      = cur & ~(wrap_bytes - axi4_addr_t'(1));
    nxt        = cur;
    case (burst)
      INCR: nxt = (cur & ~(step - axi4_addr_t'(1))) + step;
      WRAP: begin
        nxt = cur + step;
        if (nxt == lower + wrap_bytes) nxt = lower;
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Legality check of a request at acceptance. strb_w is the data bus width
  // in bytes.
  function automatic XRESP_t axi4_check_err(
    input axi4_addr_t  addr,
    input logic [7:0]  len,
    input AXSize_t     size,
    input AXBurst_t    burst,
    input int unsigned strb_w
  );
    axi4_addr_t step;
    axi4_addr_t last_byte;
    logic       err;
    step      = axi4_addr_t'(1) << size;
    last_byte = (addr & ~(step - axi4_addr_t'(1)))
              + ((axi4_addr_t'(len) + axi4_addr_t'(1)) << size) - axi4_addr_t'(1);
    err = 1'b0;
    if (step > axi4_addr_t'(strb_w)) err = 1'b1;
    if (burst == RESERVED) err = 1'b1;
    if (burst == WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) err = 1'b1;
    if (burst == WRAP && (addr & (step - axi4_addr_t'(1))) != '0) err = 1'b1;
    if (burst == FIXED && len > 8'd15) err = 1'b1;
    if (burst == INCR &&
        (addr >> AXI4_BOUNDARY_4K_LSB) != (last_byte >> AXI4_BOUNDARY_4K_LSB)) err = 1'b1;
    return err ? SLVERR : OKAY;
  endfunction

endpackage

// File: rtl/axi4_beat_strb.sv
// Byte-lane strobe for one beat: lanes from the address offset up to the end
// of the 2^size-aligned container.
// Latency: combinational. Backpressure: none (no handshake).
//
// Ports: addr_off (beat address bits inside the data bus), size (AXSize_t),
//        strb (DATA_W/8 active-lane mask).
module axi4_beat_strb
  import axi4_pkg::*;
#(
  parameter int  DATA_W = 64,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1
) (
  input  logic [OFF_W-1:0]  addr_off,
  input  AXSize_t           size,
  output logic [STRB_W-1:0] strb
);

  logic [31:0] sz;
  logic [31:0] lo;
  logic [31:0] hi;

  always_comb begin
    sz = 32'd1 << size;
    // A one-byte bus has no offset bits. Masking keeps a single lane at 0.
    lo = 32'(addr_off) & 32'(STRB_W - 1);
    hi = (lo & ~(sz - 32'd1)) + sz;
    strb = '0;
    for (int i = 0; i < STRB_W; i++) begin
      strb[i] = (32'(i) >= lo) && (32'(i) < hi);
    end
  end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst address generator: turns one AW/AR-style request into len+1 beats
// with address, strobe, last, id and a response fixed at acceptance.
// Latency: first beat 1 cycle after acceptance; 1 idle cycle between bursts.
// Backpressure: beat outputs hold while beat_valid && !beat_ready; ax_ready=0 in BURST.
//
// Ports: clk/rst (sync active-high); ax_valid/ax_ready + ax_addr/len/size/burst/id
//        request; beat_valid/beat_ready + beat_addr/strb/last/id/resp per beat.
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ax_valid,
  output logic                ax_ready,
  input  logic [ADDR_W-1:0]   ax_addr,
  input  logic [7:0]          ax_len,
  input  AXSize_t             ax_size,
  input  AXBurst_t            ax_burst,
  input  logic [ID_W-1:0]     ax_id,
  output logic                beat_valid,
  input  logic                beat_ready,
  output logic [ADDR_W-1:0]   beat_addr,
  output logic [DATA_W/8-1:0] beat_strb,
  output logic                beat_last,
  output logic [ID_W-1:0]     beat_id,
  output XRESP_t              beat_resp
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int          OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;

  burst_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [8:0]        cnt_q,   cnt_d;    // beats still to go after the current one
  logic [7:0]        len_q,   len_d;
  AXSize_t           size_q,  size_d;
  AXBurst_t          burst_q, burst_d;
  logic [ID_W-1:0]   id_q,    id_d;
  XRESP_t            resp_q,  resp_d;
  logic [STRB_W-1:0] lane_strb;

  axi4_beat_strb #(
    .DATA_W (DATA_W)
  ) u_beat_strb (
    .addr_off (addr_q[OFF_W-1:0]),
    .size     (size_q),
    .strb     (lane_strb)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    id_d    = id_q;
    resp_d  = resp_q;

    ax_ready   = (state_q == IDLE);
    beat_valid = (state_q == BURST);

    case (state_q)
      IDLE: begin
        if (ax_valid) begin
          state_d = BURST;
          addr_d  = ax_addr;
          cnt_d   = {1'b0, ax_len};
          len_d   = ax_len;
          size_d  = ax_size;
          burst_d = ax_burst;
          id_d    = ax_id;
          resp_d  = axi4_check_err(axi4_addr_t'(ax_addr), ax_len, ax_size, ax_burst, STRB_W);
        end
      end
      BURST: begin
        if (beat_ready) begin
          if (cnt_q == 9'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 9'd1;
            // An errored burst repeats the start address on every beat.
            if (resp_q == OKAY) begin
              addr_d = ADDR_W'(axi4_next_addr(axi4_addr_t'(addr_q), len_q, size_q, burst_q));
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    beat_addr = addr_q;
    beat_id   = id_q;
    beat_resp = resp_q;
    beat_last = (state_q == BURST) && (cnt_q == 9'd0);
    beat_strb = ((state_q == BURST) && (resp_q == OKAY)) ? lane_strb : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      size_q  <= S1;
      burst_q <= FIXED;
      id_q    <= '0;
      resp_q  <= OKAY;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      id_q    <= id_d;
      resp_q  <= resp_d;
    end
  end

endmodule
